// File: rtl/athos_ip_pkg.sv
// ---------------------------------------------------------------------------
// athos_ip_pkg: shared types and constants for athos_ip.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package athos_ip_pkg;

   typedef enum logic [2:0] {
      SEQ_IDLE    = 3'd0,
      SEQ_LOAD    = 3'd1,
      SEQ_COMPUTE = 3'd2,
      SEQ_STORE   = 3'd3,
      SEQ_DONE    = 3'd4
   } seq_state_t;

   typedef enum logic [1:0] {
      PH_NONE    = 2'd0,
      PH_LOAD    = 2'd1,
      PH_COMPUTE = 2'd2,
      PH_STORE   = 2'd3
   } seq_phase_t;

   localparam int OP_NULL   = 0;
   localparam int OP_KECCAK = 1;

endpackage

`default_nettype wire

// File: rtl/athos_ip_phase_cnt.sv
// ---------------------------------------------------------------------------
// athos_ip_phase_cnt: per-phase beat/cycle counter with last/zero flags.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module athos_ip_phase_cnt #(
   parameter int CNT_W = 10
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             inc_i,
   input  logic [CNT_W-1:0] len_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             last_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;

   // Clear has priority so the final beat of a phase never advances past len-1.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (inc_i) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (len_i == '0);
   assign last_o = inc_i && (cnt_q == (len_i - CNT_W'(1)));

endmodule

`default_nettype wire

// File: rtl/athos_ip_op_sequencer.sv
// ---------------------------------------------------------------------------
// athos_ip_op_sequencer: LOAD/COMPUTE/STORE command sequencer with status and irq.
// Optional busy-cycle counter via ATHOS_IP_SEQ_PERF_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module athos_ip_op_sequencer
   import athos_ip_pkg::*;
#(
   parameter int CNT_W  = 10,
   parameter int OP_W   = 6,
   parameter int PERF_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_phase_i,
   input  logic              cmd_chain_i,
   input  logic [OP_W-1:0]   operation_i,
   input  logic [CNT_W-1:0]  load_len_i,
   input  logic [CNT_W-1:0]  comp_len_i,
   input  logic [CNT_W-1:0]  store_len_i,
   input  logic              load_beat_i,
   output logic              flag_input_o,
   input  logic              store_beat_i,
   output logic              store_en_o,
   output logic              start_dp_o,
   input  logic              done_dp_i,
   output logic              busy_o,
   output logic [2:0]        phase_o,
   output logic [CNT_W-1:0]  cnt_o,
   output logic              status_done_o,
   output logic              status_err_o,
   input  logic              clr_status_i,
   output logic              intr_o,
   output logic [PERF_W-1:0] perf_cycles_o
);

   seq_state_t       state_q, state_d;
   seq_phase_t       phase_in;
   logic             chain_q;
   logic [CNT_W-1:0] load_len_q, comp_len_q, store_len_q;
   logic [CNT_W-1:0] len_sel, cnt;
   logic             accept, op_null, inc_raw, inc, clear, last, zero;
   logic             done_q, err_q;

   assign accept   = cmd_valid_i && (state_q == SEQ_IDLE);
   assign op_null  = (operation_i == OP_W'(OP_NULL));
   assign phase_in = seq_phase_t'(cmd_phase_i);

   always_comb begin
      len_sel = '0;
      inc_raw = 1'b0;
      case (state_q)
         SEQ_LOAD:    begin len_sel = load_len_q;  inc_raw = load_beat_i;  end
         SEQ_COMPUTE: begin len_sel = comp_len_q;  inc_raw = 1'b1;         end
         SEQ_STORE:   begin len_sel = store_len_q; inc_raw = store_beat_i; end
         default:     ;
      endcase
   end

   // A zero-length phase sees no beats; it simply falls through in one cycle.
   assign inc   = inc_raw && !zero;
   assign clear = (state_d != state_q);

   athos_ip_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear),
      .inc_i   (inc),
      .len_i   (len_sel),
      .cnt_o   (cnt),
      .last_o  (last),
      .zero_o  (zero)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         SEQ_IDLE: begin
            if (cmd_valid_i) begin
               if (op_null) begin
                  state_d = SEQ_DONE;
               end else begin
                  case (phase_in)
                     PH_LOAD:    state_d = SEQ_LOAD;
                     PH_COMPUTE: state_d = SEQ_COMPUTE;
                     PH_STORE:   state_d = SEQ_STORE;
                     default:    state_d = SEQ_DONE;
                  endcase
               end
            end
         end
         SEQ_LOAD: begin
            if (zero || last) state_d = chain_q ? SEQ_COMPUTE : SEQ_DONE;
         end
         SEQ_COMPUTE: begin
            if (zero || last || done_dp_i) state_d = chain_q ? SEQ_STORE : SEQ_DONE;
         end
         SEQ_STORE: begin
            if (zero || last) state_d = SEQ_DONE;
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= SEQ_IDLE;
         chain_q     <= 1'b0;
         load_len_q  <= '0;
         comp_len_q  <= '0;
         store_len_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            chain_q     <= cmd_chain_i;
            load_len_q  <= load_len_i;
            comp_len_q  <= comp_len_i;
            store_len_q <= store_len_i;
         end
      end
   end

   // Sticky status: a set in the same cycle as a clear wins.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (state_q == SEQ_DONE) done_q <= 1'b1;
         else if (clr_status_i)   done_q <= 1'b0;
         if (accept && op_null)   err_q  <= 1'b1;
         else if (clr_status_i)   err_q  <= 1'b0;
      end
   end

   assign cmd_ready_o   = (state_q == SEQ_IDLE);
   assign busy_o        = (state_q != SEQ_IDLE);
   assign phase_o       = state_q;
   assign cnt_o         = cnt;
   assign flag_input_o  = (state_q == SEQ_LOAD) && load_beat_i && !zero;
   assign store_en_o    = (state_q == SEQ_STORE);
   assign start_dp_o    = (state_q == SEQ_COMPUTE) && (cnt == '0) && !zero;
   assign intr_o        = (state_q == SEQ_DONE);
   assign status_done_o = done_q;
   assign status_err_o  = err_q;

`ifdef ATHOS_IP_SEQ_PERF_EN
   logic [PERF_W-1:0] perf_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_q <= '0;
      end else if (accept) begin
         perf_q <= '0;
      end else if (busy_o && (perf_q != '1)) begin
         perf_q <= perf_q + PERF_W'(1);
      end
   end

   assign perf_cycles_o = perf_q;
`else
   assign perf_cycles_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_athos_ip_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_athos_ip_op_sequencer: scoreboard bench for athos_ip_op_sequencer.
// Expects perf_cycles_o activity only when ATHOS_IP_SEQ_PERF_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_athos_ip_op_sequencer;
   import athos_ip_pkg::*;

   localparam int CNT_W  = 10;
   localparam int OP_W   = 6;
   localparam int PERF_W = 32;
   localparam logic [OP_W-1:0] TB_KECCAK = OP_W'(OP_KECCAK);
   localparam logic [OP_W-1:0] TB_NULL   = OP_W'(OP_NULL);
`ifdef ATHOS_IP_SEQ_PERF_EN
   localparam int EXP_PERF = 3;
`else
   localparam int EXP_PERF = 0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic              cmd_valid_i = 1'b0;
   logic              cmd_ready_o;
   logic [1:0]        cmd_phase_i = 2'd0;
   logic              cmd_chain_i = 1'b0;
   logic [OP_W-1:0]   operation_i = '0;
   logic [CNT_W-1:0]  load_len_i = '0;
   logic [CNT_W-1:0]  comp_len_i = '0;
   logic [CNT_W-1:0]  store_len_i = '0;
   logic              load_beat_i = 1'b0;
   logic              flag_input_o;
   logic              store_beat_i = 1'b0;
   logic              store_en_o;
   logic              start_dp_o;
   logic              done_dp_i = 1'b0;
   logic              busy_o;
   logic [2:0]        phase_o;
   logic [CNT_W-1:0]  cnt_o;
   logic              status_done_o;
   logic              status_err_o;
   logic              clr_status_i = 1'b0;
   logic              intr_o;
   logic [PERF_W-1:0] perf_cycles_o;

   athos_ip_op_sequencer #(.CNT_W(CNT_W), .OP_W(OP_W), .PERF_W(PERF_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_phase_i(cmd_phase_i), .cmd_chain_i(cmd_chain_i),
      .operation_i(operation_i),
      .load_len_i(load_len_i), .comp_len_i(comp_len_i), .store_len_i(store_len_i),
      .load_beat_i(load_beat_i), .flag_input_o(flag_input_o),
      .store_beat_i(store_beat_i), .store_en_o(store_en_o),
      .start_dp_o(start_dp_o), .done_dp_i(done_dp_i),
      .busy_o(busy_o), .phase_o(phase_o), .cnt_o(cnt_o),
      .status_done_o(status_done_o), .status_err_o(status_err_o),
      .clr_status_i(clr_status_i), .intr_o(intr_o),
      .perf_cycles_o(perf_cycles_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int   flags;
      int   starts;
      int   stores;
      logic err;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp_e;
   int   checks = 0;
   int   failures = 0;
   int   n_push = 0;
   int   mon_flags = 0, mon_starts = 0, mon_stores = 0, intr_seen = 0;

   // Per-command activity counters; cleared after each DONE cycle and on reset.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         mon_flags = 0; mon_starts = 0; mon_stores = 0;
      end else begin
         if (flag_input_o) mon_flags++;
         if (start_dp_o) mon_starts++;
         if (store_en_o && store_beat_i) mon_stores++;
         if (intr_o) begin
            intr_seen++;
            mon_flags = 0; mon_starts = 0; mon_stores = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic [1:0] ph, input logic ch, input logic [OP_W-1:0] op,
                        input logic [CNT_W-1:0] ll, input logic [CNT_W-1:0] cl,
                        input logic [CNT_W-1:0] sl);
      cmd_valid_i = 1'b1; cmd_phase_i = ph; cmd_chain_i = ch; operation_i = op;
      load_len_i = ll; comp_len_i = cl; store_len_i = sl;
      tick();
      cmd_valid_i = 1'b0;
   endtask

   task automatic push(input int f, input int s, input int st, input logic e);
      exp_t x;
      x.flags = f; x.starts = s; x.stores = st; x.err = e;
      exp_q.push_back(x);
      n_push++;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk_i);
      #1;
      checks++;
      if ({cmd_ready_o, busy_o, phase_o, intr_o} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_ctrl got=%b%b%0d%b exp=1000", cmd_ready_o, busy_o, phase_o, intr_o);
      end
      checks++;
      if ({cnt_o, status_done_o, status_err_o} !== '0) begin
         failures++;
         $display("FAIL reset_status got=%0d/%b/%b exp=0/0/0", cnt_o, status_done_o, status_err_o);
      end
      checks++;
      if ({flag_input_o, store_en_o, start_dp_o} !== 3'b000 || perf_cycles_o !== '0) begin
         failures++;
         $display("FAIL reset_outs got=%b%b%b/%0d exp=000/0", flag_input_o, store_en_o, start_dp_o, perf_cycles_o);
      end
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_compute();
      issue(2'd2, 1'b0, TB_KECCAK, 10'd0, 10'd24, 10'd0);
      repeat (5) tick();
      checks++;
      if (phase_o !== 3'd2 || cnt_o !== 10'd5) begin
         failures++;
         $display("FAIL midreset_pre got=%0d/%0d exp=2/5", phase_o, cnt_o);
      end
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({phase_o, busy_o, intr_o, start_dp_o, cmd_ready_o} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1} || cnt_o !== '0) begin
         failures++;
         $display("FAIL midreset_outs got=%0d%b%b%b%b/%0d exp=00001/0", phase_o, busy_o, intr_o, start_dp_o, cmd_ready_o, cnt_o);
      end
      tick();
      rst_ni = 1'b1;
      repeat (3) tick();
      checks++;
      if (phase_o !== 3'd0 || intr_seen != 0 || status_done_o !== 1'b0) begin
         failures++;
         $display("FAIL midreset_post got=%0d/%0d/%b exp=0/0/0", phase_o, intr_seen, status_done_o);
      end
   endtask

   task automatic test_chain();
      int n;
      push(4, 1, 3, 1'b0);
      issue(2'd1, 1'b1, TB_KECCAK, 10'd4, 10'd24, 10'd3);
      for (int i = 0; i < 16 && phase_o == 3'd1; i++) begin
         load_beat_i = (i % 2 == 0);
         tick();
      end
      store_beat_i = 1'b1;
      checks++;
      if (phase_o !== 3'd2 || start_dp_o !== 1'b1) begin
         failures++;
         $display("FAIL chain_compute_entry got=%0d/%b exp=2/1", phase_o, start_dp_o);
      end
      n = 0;
      while (phase_o == 3'd2 && n < 40) begin tick(); n++; end
      checks++;
      if (n != 24 || phase_o !== 3'd3) begin
         failures++;
         $display("FAIL chain_compute_len got=%0d/%0d exp=24/3", n, phase_o);
      end
      load_beat_i = 1'b0;
      n = 0;
      while (phase_o == 3'd3 && n < 10) begin tick(); n++; end
      checks++;
      if (n != 3 || phase_o !== 3'd4 || intr_o !== 1'b1) begin
         failures++;
         $display("FAIL chain_store got=%0d/%0d/%b exp=3/4/1", n, phase_o, intr_o);
      end
      exp_e = exp_q.pop_front();
      checks++;
      if (mon_flags != exp_e.flags || mon_starts != exp_e.starts || mon_stores != exp_e.stores || status_err_o !== exp_e.err) begin
         failures++;
         $display("FAIL chain_sb got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b", mon_flags, mon_starts, mon_stores, status_err_o, exp_e.flags, exp_e.starts, exp_e.stores, exp_e.err);
      end
      store_beat_i = 1'b0;
      tick();
      checks++;
      if (intr_o !== 1'b0 || phase_o !== 3'd0 || status_done_o !== 1'b1) begin
         failures++;
         $display("FAIL chain_after got=%b/%0d/%b exp=0/0/1", intr_o, phase_o, status_done_o);
      end
   endtask

   task automatic test_done_early();
      int n;
      clr_status_i = 1'b1;
      done_dp_i = 1'b1;
      tick();
      clr_status_i = 1'b0;
      checks++;
      if (status_done_o !== 1'b0 || phase_o !== 3'd0) begin
         failures++;
         $display("FAIL early_clr got=%b/%0d exp=0/0", status_done_o, phase_o);
      end
      done_dp_i = 1'b0;
      push(0, 1, 0, 1'b0);
      issue(2'd2, 1'b0, TB_KECCAK, 10'd0, 10'd906, 10'd0);
      n = 0;
      while (cnt_o != 10'd10 && n < 40) begin tick(); n++; end
      checks++;
      if (cnt_o !== 10'd10 || phase_o !== 3'd2) begin
         failures++;
         $display("FAIL early_cnt got=%0d/%0d exp=10/2", cnt_o, phase_o);
      end
      done_dp_i = 1'b1;
      tick();
      done_dp_i = 1'b0;
      checks++;
      if (phase_o !== 3'd4 || intr_o !== 1'b1) begin
         failures++;
         $display("FAIL early_done got=%0d/%b exp=4/1", phase_o, intr_o);
      end
      exp_e = exp_q.pop_front();
      checks++;
      if (mon_flags != exp_e.flags || mon_starts != exp_e.starts || mon_stores != exp_e.stores || status_err_o !== exp_e.err) begin
         failures++;
         $display("FAIL early_sb got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b", mon_flags, mon_starts, mon_stores, status_err_o, exp_e.flags, exp_e.starts, exp_e.stores, exp_e.err);
      end
      tick();
      checks++;
      if (status_done_o !== 1'b1 || phase_o !== 3'd0) begin
         failures++;
         $display("FAIL early_status got=%b/%0d exp=1/0", status_done_o, phase_o);
      end
   endtask

   task automatic test_illegal_op();
      push(0, 0, 0, 1'b1);
      issue(2'd1, 1'b0, TB_NULL, 10'd5, 10'd0, 10'd0);
      checks++;
      if (phase_o !== 3'd4 || status_err_o !== 1'b1) begin
         failures++;
         $display("FAIL null_done got=%0d/%b exp=4/1", phase_o, status_err_o);
      end
      exp_e = exp_q.pop_front();
      checks++;
      if (mon_flags != exp_e.flags || mon_starts != exp_e.starts || mon_stores != exp_e.stores || status_err_o !== exp_e.err) begin
         failures++;
         $display("FAIL null_sb got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b", mon_flags, mon_starts, mon_stores, status_err_o, exp_e.flags, exp_e.starts, exp_e.stores, exp_e.err);
      end
      tick();
      clr_status_i = 1'b1;
      tick();
      clr_status_i = 1'b0;
      checks++;
      if (status_done_o !== 1'b0 || status_err_o !== 1'b0) begin
         failures++;
         $display("FAIL null_clr got=%b/%b exp=0/0", status_done_o, status_err_o);
      end
      // Clear held through both the accept and the DONE cycle.
      push(0, 0, 0, 1'b1);
      clr_status_i = 1'b1;
      issue(2'd3, 1'b0, TB_NULL, 10'd0, 10'd0, 10'd2);
      checks++;
      if (phase_o !== 3'd4 || status_err_o !== 1'b1) begin
         failures++;
         $display("FAIL null_setwins_err got=%0d/%b exp=4/1", phase_o, status_err_o);
      end
      exp_e = exp_q.pop_front();
      checks++;
      if (mon_flags != exp_e.flags || mon_starts != exp_e.starts || mon_stores != exp_e.stores || status_err_o !== exp_e.err) begin
         failures++;
         $display("FAIL null2_sb got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b", mon_flags, mon_starts, mon_stores, status_err_o, exp_e.flags, exp_e.starts, exp_e.stores, exp_e.err);
      end
      tick();
      clr_status_i = 1'b0;
      checks++;
      if (status_done_o !== 1'b1 || status_err_o !== 1'b0 || phase_o !== 3'd0) begin
         failures++;
         $display("FAIL null_setwins_done got=%b/%b/%0d exp=1/0/0", status_done_o, status_err_o, phase_o);
      end
   endtask

   task automatic test_skip_and_busy();
      push(0, 1, 1, 1'b0);
      issue(2'd1, 1'b1, TB_KECCAK, 10'd0, 10'd2, 10'd1);
      cmd_valid_i = 1'b1; operation_i = TB_NULL; cmd_phase_i = 2'd0; load_beat_i = 1'b1;
      #1;
      checks++;
      if (phase_o !== 3'd1 || flag_input_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL skip_load got=%0d/%b/%b exp=1/0/0", phase_o, flag_input_o, cmd_ready_o);
      end
      tick();
      load_beat_i = 1'b0;
      checks++;
      if (phase_o !== 3'd2 || start_dp_o !== 1'b1 || cnt_o !== '0) begin
         failures++;
         $display("FAIL skip_to_compute got=%0d/%b/%0d exp=2/1/0", phase_o, start_dp_o, cnt_o);
      end
      tick();
      checks++;
      if (phase_o !== 3'd2 || start_dp_o !== 1'b0 || cnt_o !== 10'd1) begin
         failures++;
         $display("FAIL skip_compute2 got=%0d/%b/%0d exp=2/0/1", phase_o, start_dp_o, cnt_o);
      end
      tick();
      store_beat_i = 1'b1;
      checks++;
      if (phase_o !== 3'd3 || store_en_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL skip_store got=%0d/%b/%b exp=3/1/0", phase_o, store_en_o, cmd_ready_o);
      end
      tick();
      cmd_valid_i = 1'b0;
      store_beat_i = 1'b0;
      exp_e = exp_q.pop_front();
      checks++;
      if (phase_o !== 3'd4 || mon_flags != exp_e.flags || mon_starts != exp_e.starts || mon_stores != exp_e.stores || status_err_o !== exp_e.err) begin
         failures++;
         $display("FAIL skip_sb got=%0d:%0d/%0d/%0d/%b exp=4:%0d/%0d/%0d/%b", phase_o, mon_flags, mon_starts, mon_stores, status_err_o, exp_e.flags, exp_e.starts, exp_e.stores, exp_e.err);
      end
      repeat (2) tick();
      checks++;
      if (phase_o !== 3'd0 || busy_o !== 1'b0 || status_err_o !== 1'b0) begin
         failures++;
         $display("FAIL busy_cmd_ignored got=%0d/%b/%b exp=0/0/0", phase_o, busy_o, status_err_o);
      end
   endtask

   task automatic test_perf();
      push(2, 0, 0, 1'b0);
      issue(2'd1, 1'b0, TB_KECCAK, 10'd2, 10'd0, 10'd0);
      load_beat_i = 1'b1;
      repeat (2) tick();
      load_beat_i = 1'b0;
      exp_e = exp_q.pop_front();
      checks++;
      if (phase_o !== 3'd4 || mon_flags != exp_e.flags || mon_starts != exp_e.starts || mon_stores != exp_e.stores || status_err_o !== exp_e.err) begin
         failures++;
         $display("FAIL perf_sb got=%0d:%0d/%0d/%0d/%b exp=4:%0d/%0d/%0d/%b", phase_o, mon_flags, mon_starts, mon_stores, status_err_o, exp_e.flags, exp_e.starts, exp_e.stores, exp_e.err);
      end
      tick();
      checks++;
      if (perf_cycles_o !== PERF_W'(EXP_PERF) || phase_o !== 3'd0) begin
         failures++;
         $display("FAIL perf_cycles got=%0d/%0d exp=%0d/0", perf_cycles_o, phase_o, EXP_PERF);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_compute();
      test_chain();
      test_done_early();
      test_illegal_op();
      test_skip_and_busy();
      test_perf();
      repeat (2) tick();
      checks++;
      if (intr_seen != n_push || exp_q.size() != 0) begin
         failures++;
         $display("FAIL intr_count got=%0d/%0d exp=%0d/0", intr_seen, exp_q.size(), n_push);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
